// File: rtl/ttt_game_ctrl_pkg.sv
// Shared tic-tac-toe definitions: state encoding, cell/winner codes, key indices and line table.
// Used by the game sequencer and the display blocks.
package ttt_game_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_MAIN  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CHECK = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_X     = 2'd1;
   localparam logic [1:0] CELL_O     = 2'd2;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_X    = 2'd1;
   localparam logic [1:0] WIN_O    = 2'd2;
   localparam logic [1:0] WIN_DRAW = 2'd3;

   localparam int unsigned KEY_STAR = 9;
   localparam int unsigned KEY_HASH = 11;

   localparam int NUM_LINES = 8;
   localparam logic [3:0] MAX_MOVES = 4'd9;

   // Rows, then columns, then diagonal and anti-diagonal; matches win_line bit order.
   localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
      return b[{i, 1'b0} +: 2];
   endfunction

   function automatic logic [3:0] key_index(input logic [11:0] k);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (k[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line evaluator: flags every line fully owned by X or by O.
// No state, no handshake; the caller registers the result.
module ttt_win_check
   import ttt_game_ctrl_pkg::*;
(
   input  logic [17:0] board,
   output logic [7:0]  x_lines,
   output logic [7:0]  o_lines
);

   always_comb begin
      x_lines = '0;
      o_lines = '0;
      for (int l = 0; l < NUM_LINES; l++) begin
         x_lines[l] = (cell_at(board, LINE_CELLS[l][0]) == CELL_X) &&
                      (cell_at(board, LINE_CELLS[l][1]) == CELL_X) &&
                      (cell_at(board, LINE_CELLS[l][2]) == CELL_X);
         o_lines[l] = (cell_at(board, LINE_CELLS[l][0]) == CELL_O) &&
                      (cell_at(board, LINE_CELLS[l][1]) == CELL_O) &&
                      (cell_at(board, LINE_CELLS[l][2]) == CELL_O);
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: edge-detects keypad presses, owns board/turn/state, scores win and draw.
// Board write lands one cycle after the press, result one cycle later; presses during CHECK are dropped.
module ttt_game_ctrl
   import ttt_game_ctrl_pkg::*;
#(
   parameter bit          FIRST_O   = 1'b0,
   parameter int unsigned START_KEY = KEY_HASH,
   parameter int unsigned CLEAR_KEY = KEY_STAR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] key_data,
   output logic        is_main,
   output logic        turn_o,
   output logic [17:0] board,
   output logic [1:0]  winner,
   output logic [7:0]  win_line,
   output logic        game_over,
   output logic [3:0]  move_cnt,
   output logic        illegal
);

   state_t      state, state_nxt;
   logic [11:0] key_prev;
   logic        press;
   logic [3:0]  cell_idx;
   logic        cell_key;
   logic        clear_game;

   logic [17:0] board_nxt;
   logic        turn_nxt;
   logic [1:0]  winner_nxt;
   logic [7:0]  line_nxt;
   logic [3:0]  cnt_nxt;
   logic        illegal_nxt;

   logic [7:0]  x_lines, o_lines;

   ttt_win_check u_win_check (
      .board   (board),
      .x_lines (x_lines),
      .o_lines (o_lines)
   );

   // A press is the first cycle of a clean one-hot code after an all-released cycle.
   assign press    = (key_prev == 12'd0) && $onehot(key_data);
   assign cell_key = |key_data[8:0];
   assign cell_idx = key_index({3'b000, key_data[8:0]});

   always_comb begin
      state_nxt   = state;
      board_nxt   = board;
      turn_nxt    = turn_o;
      winner_nxt  = winner;
      line_nxt    = win_line;
      cnt_nxt     = move_cnt;
      illegal_nxt = 1'b0;
      clear_game  = 1'b0;

      unique case (state)
         ST_MAIN: begin
            if (press && key_data[START_KEY]) begin
               state_nxt  = ST_PLAY;
               clear_game = 1'b1;
            end
         end
         ST_PLAY: begin
            if (press && key_data[CLEAR_KEY]) begin
               state_nxt  = ST_MAIN;
               clear_game = 1'b1;
            end else if (press && cell_key) begin
               if (cell_at(board, cell_idx) == CELL_EMPTY) begin
                  board_nxt[{cell_idx, 1'b0} +: 2] = turn_o ? CELL_O : CELL_X;
                  cnt_nxt   = move_cnt + 4'd1;
                  state_nxt = ST_CHECK;
               end else begin
                  illegal_nxt = 1'b1;
               end
            end
         end
         ST_CHECK: begin
            // Only the mover can complete a line, so X and O never both match here.
            if (|x_lines) begin
               winner_nxt = WIN_X;
               line_nxt   = x_lines;
               state_nxt  = ST_OVER;
            end else if (|o_lines) begin
               winner_nxt = WIN_O;
               line_nxt   = o_lines;
               state_nxt  = ST_OVER;
            end else if (move_cnt == MAX_MOVES) begin
               winner_nxt = WIN_DRAW;
               line_nxt   = 8'd0;
               state_nxt  = ST_OVER;
            end else begin
               turn_nxt  = ~turn_o;
               state_nxt = ST_PLAY;
            end
         end
         ST_OVER: begin
            if (press && key_data[START_KEY]) begin
               state_nxt  = ST_PLAY;
               clear_game = 1'b1;
            end else if (press && key_data[CLEAR_KEY]) begin
               state_nxt  = ST_MAIN;
               clear_game = 1'b1;
            end
         end
         default: state_nxt = ST_MAIN;
      endcase

      if (clear_game) begin
         board_nxt  = '0;
         turn_nxt   = FIRST_O;
         winner_nxt = WIN_NONE;
         line_nxt   = 8'd0;
         cnt_nxt    = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_MAIN;
         key_prev  <= '0;
         is_main   <= 1'b1;
         turn_o    <= FIRST_O;
         board     <= '0;
         winner    <= WIN_NONE;
         win_line  <= 8'd0;
         game_over <= 1'b0;
         move_cnt  <= 4'd0;
         illegal   <= 1'b0;
      end else begin
         state     <= state_nxt;
         key_prev  <= key_data;
         is_main   <= (state_nxt == ST_MAIN);
         turn_o    <= turn_nxt;
         board     <= board_nxt;
         winner    <= winner_nxt;
         win_line  <= line_nxt;
         game_over <= (state_nxt == ST_OVER);
         move_cnt  <= cnt_nxt;
         illegal   <= illegal_nxt;
      end
   end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: stimulus queues expected output snapshots, a monitor compares them.
module tb_ttt_game_ctrl;

   localparam bit FIRST_O = 1'b0;

   logic        clk;
   logic        rst;
   logic [11:0] key_data;
   logic        is_main;
   logic        turn_o;
   logic [17:0] board;
   logic [1:0]  winner;
   logic [7:0]  win_line;
   logic        game_over;
   logic [3:0]  move_cnt;
   logic        illegal;

   ttt_game_ctrl #(
      .FIRST_O   (FIRST_O),
      .START_KEY (11),
      .CLEAR_KEY (9)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_data  (key_data),
      .is_main   (is_main),
      .turn_o    (turn_o),
      .board     (board),
      .winner    (winner),
      .win_line  (win_line),
      .game_over (game_over),
      .move_cnt  (move_cnt),
      .illegal   (illegal)
   );

   typedef struct {
      int          cyc;
      string       tag;
      logic        is_main;
      logic        turn_o;
      logic [17:0] board;
      logic [1:0]  winner;
      logic [7:0]  win_line;
      logic        game_over;
      logic [3:0]  move_cnt;
      logic        illegal;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   // Expected DUT state, hand-maintained by the stimulus.
   logic        e_main, e_turn, e_go, e_ill;
   logic [17:0] e_board;
   logic [1:0]  e_win;
   logic [7:0]  e_line;
   logic [3:0]  e_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         m = q.pop_front();
         n_chk++;
         if (m.cyc != cyc) begin
            $display("FAIL %s: expected at cycle %0d, monitor reached cycle %0d", m.tag, m.cyc, cyc);
         end else if (is_main === m.is_main && turn_o === m.turn_o && board === m.board &&
                      winner === m.winner && win_line === m.win_line && game_over === m.game_over &&
                      move_cnt === m.move_cnt && illegal === m.illegal) begin
            n_pass++;
         end else begin
            $display("FAIL %s @%0d: got main=%b turn=%b board=%h win=%0d line=%h over=%b cnt=%0d ill=%b, want main=%b turn=%b board=%h win=%0d line=%h over=%b cnt=%0d ill=%b",
                     m.tag, cyc, is_main, turn_o, board, winner, win_line, game_over, move_cnt, illegal,
                     m.is_main, m.turn_o, m.board, m.winner, m.win_line, m.game_over, m.move_cnt, m.illegal);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int ofs, input string tag);
      exp_t e;
      e.cyc = cyc + ofs;     e.tag = tag;
      e.is_main = e_main;    e.turn_o = e_turn;   e.board = e_board;
      e.winner = e_win;      e.win_line = e_line; e.game_over = e_go;
      e.move_cnt = e_cnt;    e.illegal = e_ill;
      q.push_back(e);
   endtask

   task automatic exp_reset();
      e_main = 1'b1; e_turn = FIRST_O; e_board = '0; e_win = 2'd0;
      e_line = 8'd0; e_go = 1'b0; e_cnt = 4'd0; e_ill = 1'b0;
   endtask

   task automatic exp_new_game(input logic to_main);
      exp_reset();
      e_main = to_main;
   endtask

   // Non-cell key: caller has already set the expected state one cycle after the press.
   task automatic hit(input logic [11:0] k, input string tag);
      key_data = k;
      push(1, tag);
      step(2);
      key_data = '0;
      step(1);
   endtask

   // Cell key 1..9; w/l are the hand-derived winner and win_line this move should produce.
   task automatic press_cell(input int k, input logic [1:0] w, input logic [7:0] l, input int hold);
      int          idx;
      logic [11:0] kd;
      idx = k - 1;
      kd = '0;
      kd[idx] = 1'b1;
      key_data = kd;
      if (e_go) begin
         push(1, "over_cell_ignored");
      end else if (e_board[2*idx +: 2] != 2'd0) begin
         e_ill = 1'b1;
         push(1, "illegal_pulse");
         e_ill = 1'b0;
         push(2, "illegal_one_cycle");
      end else begin
         e_board[2*idx +: 2] = e_turn ? 2'd2 : 2'd1;
         e_cnt = e_cnt + 4'd1;
         push(1, "mark_written");
         if (w != 2'd0) begin
            e_win = w; e_line = l; e_go = 1'b1;
         end else begin
            e_turn = ~e_turn;
         end
         push(2, "move_result");
      end
      step(hold);
      if (hold > 2) begin
         push(1, "held_single_mark");
         step(1);
      end
      key_data = '0;
      step(1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      key_data = '0;
      exp_reset();
      step(2);
      push(1, "reset_values");
      step(1);
      rst = 1'b0;
      push(1, "main_idle");
      step(1);
      hit(12'h001, "main_cell_ignored");

      // X wins the top row, with an illegal press mid-game.
      e_main = 1'b0; e_turn = FIRST_O;
      hit(12'h800, "start_from_main");
      press_cell(1, 2'd0, 8'h00, 2);
      press_cell(4, 2'd0, 8'h00, 2);
      press_cell(4, 2'd0, 8'h00, 2);
      press_cell(2, 2'd0, 8'h00, 2);
      press_cell(5, 2'd0, 8'h00, 2);
      press_cell(3, 2'd1, 8'h01, 2);
      e_board = 18'b00_00_00_00_10_10_01_01_01;
      push(1, "xwin_board");
      step(1);
      press_cell(9, 2'd0, 8'h00, 2);

      // Restart from OVER, then play to a draw.
      exp_new_game(1'b0);
      hit(12'h800, "restart_from_over");
      press_cell(1, 2'd0, 8'h00, 2);
      press_cell(2, 2'd0, 8'h00, 2);
      press_cell(3, 2'd0, 8'h00, 2);
      press_cell(5, 2'd0, 8'h00, 2);
      press_cell(4, 2'd0, 8'h00, 2);
      press_cell(6, 2'd0, 8'h00, 2);
      press_cell(8, 2'd0, 8'h00, 2);
      press_cell(7, 2'd0, 8'h00, 2);
      press_cell(9, 2'd3, 8'h00, 2);

      exp_new_game(1'b1);
      hit(12'h200, "clear_from_over");
      exp_new_game(1'b0);
      hit(12'h800, "start_again");
      hit(12'h400, "zero_ignored");
      hit(12'h800, "hash_in_play_ignored");
      press_cell(5, 2'd0, 8'h00, 1000);
      hit(12'h003, "multihot_ignored");
      press_cell(1, 2'd0, 8'h00, 2);
      exp_new_game(1'b1);
      hit(12'h200, "abort_mid_game");

      // O wins on the anti-diagonal.
      exp_new_game(1'b0);
      hit(12'h800, "start_o_game");
      press_cell(1, 2'd0, 8'h00, 2);
      press_cell(5, 2'd0, 8'h00, 2);
      press_cell(2, 2'd0, 8'h00, 2);
      press_cell(3, 2'd0, 8'h00, 2);
      press_cell(4, 2'd0, 8'h00, 2);
      press_cell(7, 2'd2, 8'h80, 2);

      // Reset landing while the controller sits in CHECK.
      exp_new_game(1'b0);
      hit(12'h800, "restart_before_rst");
      key_data = 12'h001;
      e_board = 18'h00001;
      e_cnt = 4'd1;
      push(1, "mark_before_rst");
      step(1);
      rst = 1'b1;
      exp_reset();
      push(1, "rst_during_check");
      step(1);
      rst = 1'b0;
      key_data = '0;
      push(1, "after_rst_idle");
      step(1);

      for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
      if (q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
